// File: rtl/pipeline_mem.sv
// pipeline_mem: instruction/data memory responder for the Pipeline core.
// Boot clears both 256x16 arrays, a load port fills imem, then the core runs.
//
// Ports:
//   clk, reset (async, active-low)
//   i_addr -> ir        : instruction fetch, 1-cycle registered
//   d_addr/rw/dw_data   : data access, dr registered, write-first
//   prog_valid/addr/data/done, prog_ready : program image load port
//   cpu_hold            : high until the image is complete
//   addr_err            : sticky out-of-range flag (fetch or store)
module pipeline_mem #(
   parameter int          DEPTH    = 256,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] i_addr,
   output logic [15:0] ir,
   input  logic [15:0] d_addr,
   input  logic        rw,
   input  logic [15:0] dw_data,
   output logic [15:0] dr,
   input  logic        prog_valid,
   input  logic [7:0]  prog_addr,
   input  logic [15:0] prog_data,
   input  logic        prog_done,
   output logic        prog_ready,
   output logic        cpu_hold,
   output logic        addr_err
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  clr_cnt;
   logic [15:0] imem [DEPTH];
   logic [15:0] dmem [DEPTH];

   logic i_in;
   logic d_in;
   logic run;

   assign i_in = (i_addr[15:8] == 8'h00);
   assign d_in = (d_addr[15:8] == 8'h00);
   assign run  = (state_q == RUN);

   assign prog_ready = (state_q == LOAD);
   assign cpu_hold   = (state_q != RUN);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT: if (clr_cnt == 8'hFF) state_d = LOAD;
         LOAD: if (prog_done) state_d = RUN;
         RUN:  state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         clr_cnt <= 8'h00;
      end else begin
         state_q <= state_d;
         if (state_q == BOOT) clr_cnt <= clr_cnt + 8'd1;
      end
   end

   // Array contents are not reset; BOOT sweeps them to zero instead.
   always_ff @(posedge clk) begin
      if (state_q == BOOT) begin
         imem[clr_cnt] <= 16'h0000;
         dmem[clr_cnt] <= 16'h0000;
      end else if (state_q == LOAD) begin
         if (prog_valid) imem[prog_addr] <= prog_data;
      end else if (run && rw && d_in) begin
         dmem[d_addr[7:0]] <= dw_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir       <= NOP_WORD;
         dr       <= 16'h0000;
         addr_err <= 1'b0;
      end else begin
         if (run && i_in) ir <= imem[i_addr[7:0]];
         else             ir <= NOP_WORD;
         if (run) begin
            if (!d_in)   dr <= 16'h0000;
            else if (rw) dr <= dw_data;
            else         dr <= dmem[d_addr[7:0]];
            if (!i_in || (!d_in && rw)) addr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_mem.sv
// tb_pipeline_mem: directed table, boot/reset sequences and a random RUN
// phase checked against a array-based model of the memory responder.
module tb_pipeline_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] i_addr, d_addr, dw_data, prog_data;
   logic        rw, prog_valid, prog_done;
   logic [7:0]  prog_addr;
   logic [15:0] ir, dr;
   logic        prog_ready, cpu_hold, addr_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] imem_m [256];
   logic [15:0] dmem_m [256];
   logic        err_m;

   typedef struct {
      logic [15:0] ia;
      logic [15:0] da;
      logic        w;
      logic [15:0] dw;
      logic [15:0] eir;
      logic [15:0] edr;
      logic        eerr;
   } vec_t;

   vec_t tv [8];

   pipeline_mem dut (
      .clk(clk), .reset(reset),
      .i_addr(i_addr), .ir(ir),
      .d_addr(d_addr), .rw(rw), .dw_data(dw_data), .dr(dr),
      .prog_valid(prog_valid), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_done(prog_done),
      .prog_ready(prog_ready), .cpu_hold(cpu_hold),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour of one RUN cycle.
   task automatic model(input logic [15:0] ia, input logic [15:0] da,
                        input logic w, input logic [15:0] dw,
                        output logic [15:0] eir, output logic [15:0] edr);
      eir = (ia < 16'h0100) ? imem_m[ia[7:0]] : 16'h0000;
      if (ia >= 16'h0100) err_m = 1'b1;
      if (da < 16'h0100) begin
         if (w) begin
            dmem_m[da[7:0]] = dw;
            edr = dw;
         end else begin
            edr = dmem_m[da[7:0]];
         end
      end else begin
         edr = 16'h0000;
         if (w) err_m = 1'b1;
      end
   endtask

   task automatic boot_wait();
      for (int i = 1; i <= 256; i++) begin
         prog_done = (i < 256);
         step();
         if (i == 1 || i >= 255) begin
            chk("boot_ready", {15'd0, prog_ready}, {15'd0, i == 256});
            chk("boot_hold", {15'd0, cpu_hold}, 16'd1);
         end
      end
      prog_done = 1'b0;
   endtask

   initial begin
      logic [15:0] eir, edr, a, d;
      reset = 1'b0;
      i_addr = 16'h0; d_addr = 16'h0; dw_data = 16'h0; rw = 1'b0;
      prog_valid = 1'b0; prog_addr = 8'h0; prog_data = 16'h0;
      prog_done = 1'b0;
      for (int i = 0; i < 256; i++) begin
         imem_m[i] = 16'h0;
         dmem_m[i] = 16'h0;
      end
      err_m = 1'b0;

      #3;
      chk("rst_ir", ir, 16'h0);
      chk("rst_dr", dr, 16'h0);
      chk("rst_err", {15'd0, addr_err}, 16'd0);
      chk("rst_ready", {15'd0, prog_ready}, 16'd0);
      chk("rst_hold", {15'd0, cpu_hold}, 16'd1);

      step();
      reset = 1'b1;
      boot_wait();

      // LOAD: core traffic must be gated while held.
      rw = 1'b1; d_addr = 16'h0005; dw_data = 16'h5555; i_addr = 16'h0003;
      for (int k = 0; k < 33; k++) begin
         case (k)
            0: begin a = 16'h03; d = 16'h0801; end
            1: begin a = 16'h03; d = 16'h1234; end
            2: begin a = 16'h00; d = 16'hAAAA; end
            default: begin
               a = 16'($urandom_range(16'h21, 16'hFF));
               d = 16'($urandom);
            end
         endcase
         prog_valid = 1'b1; prog_addr = a[7:0]; prog_data = d;
         imem_m[a[7:0]] = d;
         step();
         if (k < 4) begin
            chk("load_ready", {15'd0, prog_ready}, 16'd1);
            chk("load_hold", {15'd0, cpu_hold}, 16'd1);
            chk("load_ir_nop", ir, 16'h0);
         end
      end
      prog_addr = 8'h20; prog_data = 16'hCAFE; prog_done = 1'b1;
      imem_m[8'h20] = 16'hCAFE;
      step();
      chk("done_hold", {15'd0, cpu_hold}, 16'd0);
      chk("done_ready", {15'd0, prog_ready}, 16'd0);
      prog_done = 1'b0; rw = 1'b0;

      // RUN: load port ignored; sweep every address.
      prog_valid = 1'b1; prog_addr = 8'h03; prog_data = 16'hFFFF;
      for (int i = 0; i < 256; i++) begin
         i_addr = 16'(i); d_addr = 16'(i);
         step();
         chk($sformatf("sweep_ir[%0d]", i), ir, imem_m[i]);
         chk($sformatf("sweep_dr[%0d]", i), dr, 16'h0);
      end
      chk("sweep_err", {15'd0, addr_err}, 16'd0);
      prog_valid = 1'b0;

      tv[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0};
      tv[1] = '{16'h0004, 16'h0010, 1'b1, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0};
      tv[2] = '{16'h0020, 16'h0010, 1'b0, 16'h0000, 16'hCAFE, 16'hBEEF, 1'b0};
      tv[3] = '{16'h0000, 16'h0300, 1'b0, 16'h1111, 16'hAAAA, 16'h0000, 1'b0};
      tv[4] = '{16'h0003, 16'h0010, 1'b0, 16'h0000, 16'h1234, 16'hBEEF, 1'b0};
      tv[5] = '{16'h0100, 16'h0010, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b1};
      tv[6] = '{16'h0003, 16'h0200, 1'b1, 16'h7777, 16'h1234, 16'h0000, 1'b1};
      tv[7] = '{16'h0003, 16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b1};
      for (int i = 0; i < 8; i++) begin
         i_addr = tv[i].ia; d_addr = tv[i].da;
         rw = tv[i].w; dw_data = tv[i].dw;
         model(tv[i].ia, tv[i].da, tv[i].w, tv[i].dw, eir, edr);
         step();
         chk($sformatf("tv%0d_ir", i), ir, tv[i].eir);
         chk($sformatf("tv%0d_dr", i), dr, tv[i].edr);
         chk($sformatf("tv%0d_err", i), {15'd0, addr_err},
             {15'd0, tv[i].eerr});
      end

      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 9) == 0) ? 16'($urandom | 32'h100)
                                         : 16'($urandom_range(0, 255));
         d = ($urandom_range(0, 9) == 0) ? 16'($urandom | 32'h100)
                                         : 16'($urandom_range(0, 255));
         i_addr = a; d_addr = d;
         rw = 1'($urandom); dw_data = 16'($urandom);
         model(i_addr, d_addr, rw, dw_data, eir, edr);
         step();
         chk("rnd_ir", ir, eir);
         chk("rnd_dr", dr, edr);
         chk("rnd_err", {15'd0, addr_err}, {15'd0, err_m});
      end
      rw = 1'b0;

      // Reset in RUN: outputs drop at once, image is lost.
      reset = 1'b0;
      #2;
      chk("rrst_ir", ir, 16'h0);
      chk("rrst_dr", dr, 16'h0);
      chk("rrst_err", {15'd0, addr_err}, 16'd0);
      chk("rrst_hold", {15'd0, cpu_hold}, 16'd1);
      chk("rrst_ready", {15'd0, prog_ready}, 16'd0);
      step();
      reset = 1'b1;
      boot_wait();
      prog_done = 1'b1;
      step();
      chk("rb_hold", {15'd0, cpu_hold}, 16'd0);
      prog_done = 1'b0;
      i_addr = 16'h0000; d_addr = 16'h0010; rw = 1'b0;
      step();
      chk("rb_ir0", ir, 16'h0);
      chk("rb_dr10", dr, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
